// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters with phase FSMs and registered sync/blank/lock outputs.
// Optional o_frame_cnt frame counter when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BACK   = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [10:0] o_VGA_X,
  output logic [10:0] o_VGA_Y,
  output logic        o_VGA_lock,
  output logic        o_VGA_HS,
  output logic        o_VGA_VS,
  output logic        o_VGA_BLANK_N,
  output logic        o_VGA_SYNC_N,
  output logic        o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_FP_BEG = 11'(H_ACTIVE);
  localparam logic [10:0] H_SY_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_BP_BEG = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_FP_BEG = 11'(V_ACTIVE);
  localparam logic [10:0] V_SY_BEG = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_BP_BEG = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_e;

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  h_state_e    h_st_q, h_st_d;
  v_state_e    v_st_q, v_st_d;
  logic        h_wrap, v_step;

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;
  logic        lock_q, lock_d;
  logic        fs_q, fs_d;

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_step = i_en && h_wrap;

  // Counters and next-state; the FSM state always agrees with the counter it tracks.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_st_d  = h_st_q;
    v_st_d  = v_st_q;
    if (i_en) begin
      h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
      case (h_st_q)
        H_ACT:   if (h_cnt_d == H_FP_BEG) h_st_d = H_FP;
        H_FP:    if (h_cnt_d == H_SY_BEG) h_st_d = H_SY;
        H_SY:    if (h_cnt_d == H_BP_BEG) h_st_d = H_BP;
        H_BP:    if (h_cnt_d == 11'd0)    h_st_d = H_ACT;
        default: h_st_d = H_ACT;
      endcase
    end
    if (v_step) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
      case (v_st_q)
        V_ACT:   if (v_cnt_d == V_FP_BEG) v_st_d = V_FP;
        V_FP:    if (v_cnt_d == V_SY_BEG) v_st_d = V_SY;
        V_SY:    if (v_cnt_d == V_BP_BEG) v_st_d = V_BP;
        V_BP:    if (v_cnt_d == 11'd0)    v_st_d = V_ACT;
        default: v_st_d = V_ACT;
      endcase
    end
  end

  // Outputs decode the current counter state and appear one clock later.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    lock_d    = lock_q;
    fs_d      = 1'b0;
    if (i_en) begin
      x_d       = (h_st_q == H_ACT) ? h_cnt_q : 11'd0;
      y_d       = (v_st_q == V_ACT) ? v_cnt_q : 11'd0;
      hs_d      = (h_st_q == H_SY) ? SYNC_POL : ~SYNC_POL;
      vs_d      = (v_st_q == V_SY) ? SYNC_POL : ~SYNC_POL;
      blank_n_d = (h_st_q == H_ACT) && (v_st_q == V_ACT);
      lock_d    = (v_st_q == V_ACT);
      fs_d      = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt_q   <= 11'd0;
      v_cnt_q   <= 11'd0;
      h_st_q    <= H_ACT;
      v_st_q    <= V_ACT;
      x_q       <= 11'd0;
      y_q       <= 11'd0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      blank_n_q <= 1'b0;
      lock_q    <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_st_q    <= h_st_d;
      v_st_q    <= v_st_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      lock_q    <= lock_d;
      fs_q      <= fs_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Counts in step with the frame_start pulse it accompanies.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_q <= 16'd0;
    end else if (fs_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

  assign o_VGA_X       = x_q;
  assign o_VGA_Y       = y_q;
  assign o_VGA_HS      = hs_q;
  assign o_VGA_VS      = vs_q;
  assign o_VGA_BLANK_N = blank_n_q;
  assign o_VGA_lock    = lock_q;
  assign o_VGA_SYNC_N  = 1'b0;
  assign o_frame_start = fs_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 SHALL provide parameter H_FRONT, default 56: horizontal front porch, in clocks.
REQ-003 SHALL provide parameter H_SYNC, default 120: horizontal sync width, in clocks.
REQ-004 SHALL provide parameter H_BACK, default 64: horizontal back porch, in clocks.
REQ-005 SHALL provide parameters V_ACTIVE 600, V_FRONT 37, V_SYNC 6, V_BACK 23: the vertical equivalents, in lines.
REQ-006 SHALL provide parameter SYNC_POL, default 1: sync active level (1 = positive).
REQ-007 SHALL have port i_clk, input, 1: pixel clock; one clock = one pixel.
REQ-008 SHALL have port i_rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port i_en, input, 1: timing runs when 1; counters hold when 0.
REQ-010 SHALL have port o_VGA_X, output, 11: active-area column.
REQ-011 SHALL have port o_VGA_Y, output, 11: active-area row.
REQ-012 SHALL have port o_VGA_lock, output, 1: high throughout the vertical active region; renderer buffers update only while it is low.
REQ-013 SHALL have ports o_VGA_HS and o_VGA_VS, output, 1 each: horizontal and vertical sync.
REQ-014 SHALL have port o_VGA_BLANK_N, output, 1: high only on active pixels.
REQ-015 SHALL have port o_VGA_SYNC_N, output, 1: tied to 0.
REQ-016 SHALL have port o_frame_start, output, 1: one-clock pulse at pixel (0,0).

Function
REQ-017 SHALL keep h_cnt in 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 1040).
REQ-018 SHALL keep v_cnt in 0..V_TOTAL-1, default V_TOTAL 666.
REQ-019 SHALL, when i_en=1, increment h_cnt every clock and wrap it from H_TOTAL-1 to 0.
REQ-020 SHALL increment v_cnt only on h_cnt wrap, and wrap v_cnt from V_TOTAL-1 to 0 on that same edge.
REQ-021 SHALL implement a horizontal FSM H_ACT -> H_FP -> H_SY -> H_BP -> H_ACT, transitioning when h_cnt reaches the respective boundary (H_ACTIVE, +H_FRONT, +H_SYNC, H_TOTAL).
REQ-022 SHALL implement an equivalent vertical FSM V_ACT -> V_FP -> V_SY -> V_BP, stepped only on h_cnt wrap.
REQ-023 SHALL register all outputs, with exactly 1 clock of latency from the counter state.
REQ-024 SHALL drive o_VGA_X = h_cnt during H_ACT and 0 otherwise; o_VGA_Y = v_cnt during V_ACT and 0 otherwise.
REQ-025 SHALL drive o_VGA_BLANK_N = (H_ACT && V_ACT).
REQ-026 SHALL assert HS at level SYNC_POL only in H_SY, and VS only in V_SY.
REQ-027 SHALL set o_VGA_lock=1 from the first clock of v_cnt=0 through the last clock of v_cnt=V_ACTIVE-1, and 0 for the whole vertical blanking interval.
REQ-028 SHALL assert o_frame_start for exactly one clock per frame, when h_cnt=0 and v_cnt=0 are presented.
REQ-029 SHALL, when i_en=0, freeze counters, FSMs and all outputs with no pulse repeat; o_frame_start SHALL be 0 while held.
REQ-030 SHALL resume from the held position when i_en returns to 1.
REQ-031 SHALL, on simultaneous h and v wrap, go to (0,0) in a single clock with no extra blank line.

Reset
REQ-032 SHALL asynchronously clear h_cnt and v_cnt to 0 and force the FSMs to H_ACT / V_ACT when i_rst=1.
REQ-033 SHALL reset outputs to X=0, Y=0, lock=0, BLANK_N=0, frame_start=0, and HS/VS inactive (~SYNC_POL).
REQ-034 SHALL restart from (0,0) after reset is released mid-frame, with the first o_frame_start 1 clock after the first enabled edge.

Configuration
REQ-035 SHALL, with VGA_TIMING_FRAME_CNT_EN defined, add output o_frame_cnt [15:0], reset to 0, incremented with each o_frame_start and wrapping 65535 -> 0.
REQ-036 SHALL, without VGA_TIMING_FRAME_CNT_EN, omit that port and its register.

Verification
REQ-037 SHALL verify: reset release with i_en=1 -> o_frame_start=1 at clock 1; HS active for clocks 857..976 of line 0 (120 clocks).
REQ-038 SHALL verify: run 1040*666 clocks -> exactly one o_frame_start; o_VGA_lock high for 600*1040 clocks and low for 66*1040 clocks.
REQ-039 SHALL verify: the pixel at h_cnt=799, v_cnt=599 -> X=799, Y=599, BLANK_N=1; the next clock -> X=0, BLANK_N=0, lock stays 1 to end of line.
REQ-040 SHALL verify: i_en=0 for 50 clocks mid-line at X=300 -> outputs frozen at X=300; on re-enable the next X=301.
REQ-041 SHALL verify: i_rst pulse at v_cnt=620 -> all outputs at reset values immediately (asynchronous), then a restart from (0,0).
REQ-042 SHALL verify, with VGA_TIMING_FRAME_CNT_EN and 3 full frames run -> o_frame_cnt=3; with the counter preloaded to 65535 via force -> wraps to 0.
